// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

  localparam int FETCH_XLEN = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // RUN: a credit is available for a new read; HOLD: credits exhausted
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - imem request/response and decode-side handshake bundle
interface fetch_queue_if #(
  parameter int XLEN = 64
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  // fetch stage side
  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  // memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO with synchronous flush and occupancy output
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // a flush discards both the pending push and pop; popping empty is a no-op
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  assign head_data = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage write; the upstream credit check must keep pushes off a full queue
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (!reset) assert (!(do_push && !do_pop && count == FULL_CNT));
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with redirect; FETCH_PERF_EN adds stall/flush counters
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  fetch_state_t   state;
  fetch_state_t   state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN+31:0] head_data;

  // RUN state already encodes "occupancy + inflight < DEPTH" from registered values
  assign issue = (state == ST_RUN) && !bus.redirect && !reset;
  assign push  = inflight && !bus.redirect;
  assign pop   = bus.out_valid && bus.out_ready && !bus.redirect;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = bus.out_valid ? head_data[XLEN+31:32] : '0;
  assign bus.out_instr = bus.out_valid ? head_data[31:0] : '0;

  fetch_fifo #(
    .WIDTH(XLEN + 32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.redirect),
    .push     (push),
    .push_data({inflight_pc, bus.imem_rdata}),
    .pop      (pop),
    .head_data(head_data),
    .count    (count)
  );

  // credit state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // next credit state from next-cycle occupancy plus the read issued now
  always_comb begin
    count_next = count;
    state_next = state;
    if (bus.redirect) begin
      count_next = '0;
      state_next = ST_RUN;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
      state_next = ((count_next + CW'(issue)) < DEPTH_CNT) ? ST_RUN : ST_HOLD;
    end
  end

  // fetch PC and in-flight tracking; redirect retargets to the word-aligned PC
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC & WORD_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc & WORD_MASK;
      end else if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(INSTR_BYTES);
        inflight_pc <= fetch_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // saturating counters for decode back-pressure and redirect flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.redirect && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue (build with FETCH_PERF_EN for counter checks)
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  fetch_queue_if #(.XLEN(64)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_queue #(
    .XLEN(64),
    .DEPTH(4),
    .RESET_PC(64'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0013;
  endfunction

  // instruction memory: samples the request just before the edge, answers just after it
  logic        mem_req_s;
  logic [63:0] mem_addr_s;
  initial begin
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      mem_req_s  = bus.imem_req;
      mem_addr_s = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rdata = mem_req_s ? mem_word(mem_addr_s) : 32'hDEAD_BEEF;
    end
  end

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.out_ready = rdy;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.out_pc); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", bus.out_instr); end
    reset = 1'b0;
    #1;
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h0}) begin bad++; $display("FAIL reset_first_issue got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'(c * 4)}) begin bad++; $display("FAIL stream_issue c=%0d got req=%b addr=%h want req=1 addr=%h", c, bus.imem_req, bus.imem_addr, 64'(c * 4)); end
      total++; if (bus.out_valid !== (c >= 2)) begin bad++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, bus.out_valid, (c >= 2)); end
      if (c >= 2) begin
        total++; if (bus.out_pc !== 64'((c - 2) * 4)) begin bad++; $display("FAIL stream_pc c=%0d got=%h want=%h", c, bus.out_pc, 64'((c - 2) * 4)); end
        total++; if (bus.out_instr !== mem_word(64'((c - 2) * 4))) begin bad++; $display("FAIL stream_instr c=%0d got=%h want=%h", c, bus.out_instr, mem_word(64'((c - 2) * 4))); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full;
    int nreq;
    int pops;
    logic [63:0] exp_pc;
    nreq = 0;
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (bus.imem_req !== (c <= 3)) begin bad++; $display("FAIL full_req c=%0d got=%b want=%b", c, bus.imem_req, (c <= 3)); end
      if (bus.imem_req === 1'b1) begin
        nreq++;
        total++; if (bus.imem_addr !== 64'(c * 4)) begin bad++; $display("FAIL full_addr c=%0d got=%h want=%h", c, bus.imem_addr, 64'(c * 4)); end
      end
      total++; if (bus.out_valid !== (c >= 2)) begin bad++; $display("FAIL full_valid c=%0d got=%b want=%b", c, bus.out_valid, (c >= 2)); end
      if (c >= 2) begin
        total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL full_head_hold c=%0d got=%h want=0", c, bus.out_pc); end
      end
      @(negedge clk);
    end
    total++; if (nreq !== 4) begin bad++; $display("FAIL full_req_count got=%0d want=4", nreq); end
    bus.out_ready = 1'b1;
    exp_pc = 64'h0;
    pops = 0;
    for (int k = 0; k < 30 && pops < 8; k++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL drain_pc got=%h want=%h", bus.out_pc, exp_pc); end
        total++; if (bus.out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL drain_instr got=%h want=%h", bus.out_instr, mem_word(exp_pc)); end
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      @(negedge clk);
    end
    total++; if (pops !== 8) begin bad++; $display("FAIL drain_timeout pops=%0d want=8", pops); end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h0}) begin bad++; $display("FAIL redir_pre got valid=%b pc=%h want valid=1 pc=0", bus.out_valid, bus.out_pc); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h100;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_blocked got=%b want=0", bus.imem_req); end
    @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_t1_valid got=%b want=0", bus.out_valid); end
    bus.redirect = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h100}) begin bad++; $display("FAIL redir_t1_issue got req=%b addr=%h want req=1 addr=100", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_t2_valid got=%b want=0", bus.out_valid); end
    @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h100}) begin bad++; $display("FAIL redir_t3_head got valid=%b pc=%h want valid=1 pc=100", bus.out_valid, bus.out_pc); end
    total++; if (bus.out_instr !== mem_word(64'h100)) begin bad++; $display("FAIL redir_t3_instr got=%h want=%h", bus.out_instr, mem_word(64'h100)); end
    @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h104}) begin bad++; $display("FAIL redir_t4_head got valid=%b pc=%h want valid=1 pc=104", bus.out_valid, bus.out_pc); end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h102;
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h100}) begin bad++; $display("FAIL misalign_issue got req=%b addr=%h want req=1 addr=100", bus.imem_req, bus.imem_addr); end
    repeat (2) @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h100}) begin bad++; $display("FAIL misalign_head got valid=%b pc=%h want valid=1 pc=100", bus.out_valid, bus.out_pc); end
    @(negedge clk);
  endtask

  task automatic test_redirect_pop;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h4}) begin bad++; $display("FAIL rpop_pre got valid=%b pc=%h want valid=1 pc=4", bus.out_valid, bus.out_pc); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h200;
    @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rpop_empty got=%b want=0", bus.out_valid); end
    bus.redirect = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rpop_t2_valid got=%b want=0", bus.out_valid); end
    @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h200}) begin bad++; $display("FAIL rpop_t3_head got valid=%b pc=%h want valid=1 pc=200", bus.out_valid, bus.out_pc); end
    @(negedge clk);
  endtask

  task automatic test_redirect_reset;
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h300;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rrst_req got=%b want=0", bus.imem_req); end
    @(negedge clk);
    reset = 1'b0;
    bus.redirect = 1'b0;
    #1;
    total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h0}) begin bad++; $display("FAIL rrst_issue got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rrst_valid got=%b want=0", bus.out_valid); end
    repeat (2) @(negedge clk);
    #1;
    total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h0}) begin bad++; $display("FAIL rrst_head got valid=%b pc=%h want valid=1 pc=0", bus.out_valid, bus.out_pc); end
    @(negedge clk);
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf;
    do_reset(1'b1);
    #1;
    total++; if ({perf_stall_cnt, perf_flush_cnt} !== 64'h0) begin bad++; $display("FAIL perf_reset got stall=%0d flush=%0d want 0 0", perf_stall_cnt, perf_flush_cnt); end
    repeat (4) @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL perf_nonempty got=%b want=1", bus.out_valid); end
    total++; if (perf_stall_cnt !== 32'd10) begin bad++; $display("FAIL perf_stall got=%0d want=10", perf_stall_cnt); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    bus.redirect = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    total++; if (perf_flush_cnt !== 32'd2) begin bad++; $display("FAIL perf_flush got=%0d want=2", perf_flush_cnt); end
    total++; if (perf_stall_cnt !== 32'd10) begin bad++; $display("FAIL perf_stall_after got=%0d want=10", perf_stall_cnt); end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_misaligned();
    test_redirect_pop();
    test_redirect_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the single-cycle decode/execute datapath.
- Owns the fetch PC and issues word reads to instruction memory, which has a fixed 1-cycle read latency.
- Buffers returned {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing all stale fetches.

Parameters:
- XLEN, 64, PC/address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 64'h0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  word address of request; bits [1:0] always 0.
- imem_rdata  in  32  instruction data, valid the cycle after imem_req.
- redirect  in  1  branch/jump taken; load new PC.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode consumes head.
- out_pc  out  XLEN  PC of head instruction.
- out_instr  out  32  head instruction.

Behaviour:
- Reset (while reset=1 at a clock edge):
  - fetch PC = RESET_PC; FIFO empty; in-flight flag cleared.
  - imem_req=0, out_valid=0, out_pc=0, out_instr=0.
- Issue:
  - imem_req=1 when occupancy + inflight < DEPTH and redirect=0.
  - imem_addr = fetch PC. On issue, fetch PC += 4 (wraps modulo 2^XLEN) and inflight is set for the next cycle.
  - imem_req is combinational from registered state and redirect.
- Response:
  - The cycle after an issue, if not squashed, {issued pc, imem_rdata} is pushed into the FIFO.
  - The credit check guarantees a push never overflows; an overflow is an assertion failure.
- Output:
  - out_valid = (occupancy != 0); out_pc/out_instr show the FIFO head.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Head fields hold stable while out_valid=1 and out_ready=0.
- Redirect (priority over everything except reset):
  - The FIFO is flushed: occupancy=0, so out_valid=0 next cycle. Any pop in the same cycle is ignored.
  - A response arriving in the redirect cycle is discarded.
  - fetch PC = {redirect_pc[XLEN-1:2], 2'b00}.
  - imem_req=0 in the redirect cycle; the first fetch of the target is issued the following cycle.
  - Redirect-to-first-valid-output latency is 3 cycles: issue at t+1, push at t+2, out_valid at t+3.
- Steady state: with out_ready held at 1, one instruction per cycle after a 2-cycle startup.
- Full: no issue until a pop frees a credit. Pop and issue may occur in the same cycle; the credit is counted from registered occupancy, which costs one bubble at full.
- Empty with out_ready=1: no pop; pointers unchanged.
- State machine, two states:
  - RUN: issuing normally.
  - HOLD: credits exhausted.
  - Transitions follow the credit check. redirect forces RUN with an empty FIFO.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports perf_stall_cnt (32 bits) and perf_flush_cnt (32 bits), both reset to 0.
  - perf_stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - perf_flush_cnt increments each redirect cycle.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_entry_t {pc[XLEN-1:0], instr[31:0]}.
  - constants INSTR_BYTES=4 and NOP_INSTR=32'h0000_0013.
- One sub-module, fetch_fifo: parameterised DEPTH, synchronous flush, push/pop, occupancy output.
- The top level holds the PC, in-flight tracking, the credit check and the redirect logic.

Test Plan:
- Reset, then out_ready=1 and imem returning mem[addr]:
  - imem_addr sequence is 0, 4, 8, …
  - out_valid first rises at cycle 2 with out_pc=0, then one instruction per cycle.
- out_ready=0 after reset, DEPTH=4:
  - Exactly 4 requests issued, addresses 0, 4, 8, 12; then imem_req=0.
  - Head held at pc=0.
  - After out_ready=1, in-order pops 0, 4, 8, 12, 16, …
- Redirect to 64'h100 while the FIFO holds 3 entries and one read is in flight:
  - Next cycle out_valid=0; the in-flight data is never output.
  - imem_addr=64'h100 on cycle t+1; out_pc=64'h100 at t+3.
- Redirect to 64'h102: fetch address is 64'h100.
- Redirect asserted together with a pop, and together with reset:
  - With the pop: the pop is ignored and the FIFO is empty.
  - With reset: reset wins and fetch PC = RESET_PC.
- With FETCH_PERF_EN defined:
  - Hold out_ready=0 for 10 cycles with the FIFO non-empty → perf_stall_cnt=10.
  - Two redirects → perf_flush_cnt=2.
